// File: rtl/id_stage_fwd.sv
// id_stage_fwd: RV64I decode stage with prioritised operand bypass, load-use
// interlock and a registered ID/EX slot behind valid/ready handshakes.
module id_stage_fwd #(
  parameter int XLEN     = 64,
  parameter int NUM_FWD  = 3,
  parameter int STALL_CW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [NUM_FWD*5-1:0]    fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_rs1_val,
  output logic [XLEN-1:0]         out_rs2_val,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_rd,
  output logic                    out_wen,
  output logic [STALL_CW-1:0]     stall_cycles
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic [4:0]      fwd_addr_a [NUM_FWD];
  logic [XLEN-1:0] fwd_data_a [NUM_FWD];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_unpack
      assign fwd_addr_a[gi] = fwd_addr[gi*5 +: 5];
      assign fwd_data_a[gi] = fwd_data[gi*XLEN +: XLEN];
    end
  endgenerate

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode    = in_inst[6:0];
  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pend;
  logic            rs2_pend;

  // Scan from the oldest source up so the youngest match overrides.
  always_comb begin
    rs1_val  = rf_rdata1;
    rs2_val  = rf_rdata2;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_addr_a[i] == rs1) begin
        rs1_val  = fwd_data_a[i];
        rs1_pend = fwd_pending[i];
      end
      if (fwd_en[i] && fwd_addr_a[i] == rs2) begin
        rs2_val  = fwd_data_a[i];
        rs2_pend = fwd_pending[i];
      end
    end
    if (rs1 == 5'd0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
    if (rs2 == 5'd0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

  logic is_r;
  logic is_s;
  logic is_b;
  logic is_u;
  logic is_j;

  assign is_r = (opcode == OP_OP) || (opcode == OP_OP32);
  assign is_s = (opcode == OP_STORE);
  assign is_b = (opcode == OP_BRANCH);
  assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign is_j = (opcode == OP_JAL);

  // Anything not R/S/B/U/J decodes as I-format.
  logic [31:0] imm32;
  always_comb begin
    imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    if (is_r) begin
      imm32 = '0;
    end else if (is_s) begin
      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    end else if (is_b) begin
      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
               in_inst[11:8], 1'b0};
    end else if (is_u) begin
      imm32 = {in_inst[31:12], 12'b0};
    end else if (is_j) begin
      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
               in_inst[30:21], 1'b0};
    end
  end

  logic rs1_used;
  logic rs2_used;
  logic hazard;
  logic accept;

  assign rs1_used = !(is_u || is_j);
  assign rs2_used = is_r || is_s || is_b;
  assign hazard   = in_valid && ((rs1_used && rs1_pend) || (rs2_used && rs2_pend));

  logic                valid_q, valid_d;
  logic [31:0]         inst_q, inst_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]     rs2_val_q, rs2_val_d;
  logic [XLEN-1:0]     imm_q, imm_d;
  logic [4:0]          rd_q, rd_d;
  logic                wen_q, wen_d;
  logic [STALL_CW-1:0] stall_q, stall_d;

  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    stall_d   = stall_q;
    if (hazard && !flush && stall_q != '1) begin
      stall_d = stall_q + STALL_CW'(1);
    end
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      inst_d    = in_inst;
      pc_d      = in_pc;
      rs1_val_d = rs1_val;
      rs2_val_d = rs2_val;
      imm_d     = {{(XLEN-32){imm32[31]}}, imm32};
      rd_d      = in_inst[11:7];
      wen_d     = !(is_s || is_b) && (in_inst[11:7] != 5'd0);
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_inst     = inst_q;
  assign out_pc       = pc_q;
  assign out_rs1_val  = rs1_val_q;
  assign out_rs2_val  = rs2_val_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_wen      = wen_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed scenarios plus randomized traffic, checked
// against an instruction-level reference model that encodes from chosen immediates.
module tb_id_stage_fwd;
  localparam int XLEN = 64;
  localparam int NF   = 3;
  localparam int SCW  = 32;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_S = 3, K_B = 4, K_U = 5, K_J = 6, K_JR = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, in_valid, in_ready, out_valid, out_ready, out_wen;
  logic [31:0]       in_inst, out_inst;
  logic [XLEN-1:0]   in_pc, rf_rdata1, rf_rdata2, out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]        rf_raddr1, rf_raddr2, out_rd;
  logic [NF-1:0]     fwd_en, fwd_pending;
  logic [NF*5-1:0]   fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;
  logic [SCW-1:0]    stall_cycles;

  id_stage_fwd #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CW(SCW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd(out_rd), .out_wen(out_wen),
    .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          cur_kind;
  logic [31:0] cur_imm;
  logic [63:0] regs [32];

  logic        m_valid, m_wen;
  logic [31:0] m_inst, m_stall;
  logic [63:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic uses_rs1(input int kind);
    return !(kind == K_U || kind == K_J);
  endfunction

  function automatic logic uses_rs2(input int kind);
    return (kind == K_R || kind == K_S || kind == K_B);
  endfunction

  // Youngest enabled source naming the register wins; x0 is hardwired.
  function automatic void ref_operand(input logic [4:0] rs, input logic [63:0] rf,
                                      output logic [63:0] val, output logic pend);
    logic found;
    val = rf;
    pend = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (!found && fwd_en[i] && fwd_addr[i*5 +: 5] == rs) begin
        val   = fwd_data[i*64 +: 64];
        pend  = fwd_pending[i];
        found = 1'b1;
      end
    end
    if (rs == 5'd0) begin
      val  = 64'd0;
      pend = 1'b0;
    end
  endfunction

  task automatic set_inst(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm);
    cur_kind = kind;
    cur_imm  = imm;
    case (kind)
      K_R:  in_inst = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_I:  in_inst = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      K_LD: in_inst = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      K_JR: in_inst = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      K_S:  in_inst = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      K_B:  in_inst = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      K_U:  in_inst = {imm[31:12], rd, 7'b0110111};
      default: in_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
  endtask

  function automatic logic [31:0] rand_imm(input int kind);
    int v;
    case (kind)
      K_R:     v = 0;
      K_B:     v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      K_U:     v = int'($urandom & 32'hFFFF_F000);
      K_J:     v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: v = int'($urandom_range(0, 4095)) - 2048;
    endcase
    return v;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model, check the slot.
  task automatic step();
    logic [63:0] v1, v2;
    logic        p1, p2, hz, rdy;
    logic [4:0]  a1, a2;
    a1 = in_inst[19:15];
    a2 = in_inst[24:20];
    rf_rdata1 = regs[a1];
    rf_rdata2 = regs[a2];
    @(negedge clk);
    ref_operand(a1, rf_rdata1, v1, p1);
    ref_operand(a2, rf_rdata2, v2, p2);
    hz  = in_valid && ((uses_rs1(cur_kind) && p1) || (uses_rs2(cur_kind) && p2));
    rdy = !hz && !flush && (!m_valid || out_ready);
    check("rf_raddr1", rf_raddr1, a1);
    check("rf_raddr2", rf_raddr2, a2);
    check("in_ready", in_ready, rdy);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_inst = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_rd = 0; m_wen = 0; m_stall = 0;
    end else begin
      if (hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && rdy) begin
        m_valid = 1;
        m_inst  = in_inst;
        m_pc    = in_pc;
        m_rs1   = v1;
        m_rs2   = v2;
        m_imm   = (cur_kind == K_R) ? 64'd0 : {{32{cur_imm[31]}}, cur_imm};
        m_rd    = in_inst[11:7];
        m_wen   = !(cur_kind == K_S || cur_kind == K_B) && (in_inst[11:7] != 5'd0);
      end else if (out_ready && m_valid) begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("stall_cycles", stall_cycles, m_stall);
    if (m_valid) begin
      check("out_inst", out_inst, m_inst);
      check("out_pc", out_pc, m_pc);
      check("out_rs1_val", out_rs1_val, m_rs1);
      check("out_rs2_val", out_rs2_val, m_rs2);
      check("out_imm", out_imm, m_imm);
      check("out_rd", out_rd, m_rd);
      check("out_wen", out_wen, m_wen);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_inst"}, out_inst, 0);
    check({tag, "_pc"}, out_pc, 0);
    check({tag, "_rs1"}, out_rs1_val, 0);
    check({tag, "_rs2"}, out_rs2_val, 0);
    check({tag, "_imm"}, out_imm, 0);
    check({tag, "_rd"}, out_rd, 0);
    check({tag, "_wen"}, out_wen, 0);
    check({tag, "_stall"}, stall_cycles, 0);
  endtask

  initial begin
    logic [31:0] s0;
    int          k;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    fwd_en = 0; fwd_addr = 0; fwd_data = 0; fwd_pending = 0; in_pc = 0;
    rf_rdata1 = 0; rf_rdata2 = 0;
    m_valid = 0; m_stall = 0;
    set_inst(K_I, 0, 0, 0, 0);
    step(); step();
    check_zero("reset");
    reset = 0;

    // back-to-back: addi x1,x0,5 ; add x2,x1,x1 with x1 bypassed
    in_valid = 1; in_pc = 64'h1000;
    set_inst(K_I, 1, 0, 0, 5);
    step();
    check("b2b_first_imm", out_imm, 5);
    fwd_en = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd1}; fwd_data = {64'd0, 64'd0, 64'd5};
    in_pc = 64'h1004;
    set_inst(K_R, 2, 1, 1, 0);
    step();
    check("b2b_rs1", out_rs1_val, 5);
    check("b2b_rs2", out_rs2_val, 5);
    check("b2b_pc", out_pc, 64'h1004);

    // priority: sources 0 and 2 both name x3
    fwd_en = 3'b101; fwd_addr = {5'd3, 5'd0, 5'd3}; fwd_data = {64'd9, 64'd0, 64'd7};
    set_inst(K_R, 8, 3, 0, 0);
    step();
    check("prio_rs1", out_rs1_val, 7);
    fwd_en = 3'b001; fwd_addr = 0; fwd_data = {64'd0, 64'd0, 64'd123};
    set_inst(K_R, 9, 0, 0, 0);
    step();
    check("x0_rs1", out_rs1_val, 0);

    // load-use interlock on x4
    fwd_en = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd4}; fwd_pending = 3'b001;
    fwd_data = {64'd0, 64'd0, 64'hDEAD};
    s0 = m_stall;
    set_inst(K_R, 10, 4, 0, 0);
    repeat (3) begin
      step();
      check("lu_in_ready", in_ready, 0);
    end
    check("lu_stall", stall_cycles, s0 + 3);
    fwd_pending = 0; fwd_data = {64'd0, 64'd0, 64'd42};
    step();
    check("lu_release_rs1", out_rs1_val, 42);
    fwd_en = 0;

    // backpressure: 3 cycles of out_ready=0 then release
    out_ready = 0; in_pc = 64'h2000;
    set_inst(K_I, 11, 1, 0, 16);
    repeat (3) step();
    out_ready = 1;
    step();
    check("bp_next_pc", out_pc, 64'h2000);

    // flush while full, then flush while stalled
    flush = 1; step();
    check("flush_full", out_valid, 0);
    flush = 0;
    fwd_en = 3'b010; fwd_addr = {5'd0, 5'd5, 5'd0}; fwd_pending = 3'b010;
    set_inst(K_S, 0, 5, 6, 8);
    step();
    flush = 1; step();
    check("flush_stall", out_valid, 0);
    flush = 0; fwd_pending = 0; step();
    in_valid = 0; step(); step();

    // reset in the middle of a stall
    in_valid = 1; fwd_pending = 3'b010;
    step(); step();
    reset = 1; step();
    check_zero("rst_stall");
    reset = 0; fwd_en = 0; fwd_pending = 0;

    // decode spot checks
    set_inst(K_S, 0, 6, 5, -4);
    step();
    check("sw_wen", out_wen, 0);
    check("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    set_inst(K_B, 0, 1, 2, 8);
    step();
    check("beq_wen", out_wen, 0);
    set_inst(K_U, 7, 0, 0, 32'h1234_5000);
    step();
    check("lui_imm", out_imm, 64'h1234_5000);
    check("lui_wen", out_wen, 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      in_valid    = ($urandom_range(0, 99) < 85);
      out_ready   = ($urandom_range(0, 99) < 70);
      in_pc       = {$urandom, $urandom};
      fwd_en      = NF'($urandom);
      fwd_pending = NF'($urandom_range(0, 7) == 0 ? $urandom : 0);
      for (int i = 0; i < NF; i++) begin
        fwd_addr[i*5 +: 5]  = 5'($urandom_range(0, 7));
        fwd_data[i*64 +: 64] = {$urandom, $urandom};
      end
      k = $urandom_range(0, 7);
      set_inst(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), rand_imm(k));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
